// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encodings, opcodes, ALU op classes and mux select codes
// shared by the multicycle MIPS controller.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BEQ, S_ADDIEX, S_ORIEX, S_IWB, S_JUMP, S_JAL, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
endpackage

// File: rtl/mips_wait_timer.sv
// mips_wait_timer: counts consecutive stalled cycles; expire is high while the
// count equals TIMEOUT, and the count restarts from zero the cycle after.
module mips_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expire = cnt == W'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear || expire) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multicycle MIPS control FSM with memory wait timeout.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap undefined opcodes instead of treating them as NOP.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W         = 6,
  parameter int ALUOP_W      = 2,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               mem_timeout,
  output logic               illegal_op
);
  state_t state, next;
  logic wait_st, expire, timeout, clear;
  assign wait_st     = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign timeout     = wait_st & expire;
  assign clear       = mem_ready | (next != state);
  assign mem_timeout = timeout;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = state == S_TRAP;
`else
  assign illegal_op = 1'b0;
`endif
  mips_wait_timer #(.TIMEOUT(WAIT_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (wait_st & ~mem_ready),
    .clear  (clear),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  // Strobes in wait states are gated by timeout so an abandoned access writes nothing.
  always_comb begin
    next       = state;
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_ADD;
    pc_src     = PCS_ALU;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        mem_read  = ~timeout;
        ir_write  = mem_ready & ~timeout;
        pc_write  = mem_ready & ~timeout;
        next      = (mem_ready && !timeout) ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BR;
        case (op)
          OP_RTYPE:     next = S_EXEC;
          OP_LW, OP_SW: next = S_MEMADR;
          OP_BEQ:       next = S_BEQ;
          OP_ADDI:      next = S_ADDIEX;
          OP_ORI:       next = S_ORIEX;
          OP_J:         next = S_JUMP;
          OP_JAL:       next = S_JAL;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          default:      next = S_TRAP;
`else
          default:      next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        next      = op == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = ~timeout;
        next     = timeout ? S_FETCH : mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        next       = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = ~timeout;
        next      = (timeout || mem_ready) ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
        next      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = PCS_ALUOUT;
        next      = S_FETCH;
      end
      S_ADDIEX, S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = state == S_ORIEX ? ALUOP_OR : ALUOP_ADD;
        next      = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        next      = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCS_JUMP;
        next     = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PCS_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RD_RA;
        mem_to_reg = M2R_PC;
        next       = S_FETCH;
      end
      S_TRAP:  next = S_TRAP;
      default: next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed and randomized instruction streams checked
// against per-instruction cycle scripts derived from the controller's behaviour.
module tb_mips_multicycle_controller;
  typedef struct packed {
    logic       pc_write, branch, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       mem_timeout, illegal_op;
  } ctrl_t;
  localparam int WT = 15;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000, OI = 6'b001101, JJ = 6'b000010, JL = 6'b000011;
  logic clk = 1'b0, rst_n = 1'b1, mem_ready = 1'b0;
  logic [5:0] op = '0;
  logic pc_write, branch, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic mem_timeout, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  ctrl_t obs;
  int checks = 0, errors = 0;
  mips_multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .mem_timeout(mem_timeout), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  assign obs = {pc_write, branch, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, mem_timeout, illegal_op};
  task automatic chk(input string tag, input ctrl_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Called just after a rising edge: drive mem_ready, check mid-cycle, advance one clock.
  task automatic cyc(input logic rdy, input string tag, input ctrl_t exp);
    mem_ready = rdy;
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("reset_async", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'($urandom), "idle", '0);
  endtask
  task automatic fetch(input int w, output bit ok);
    ctrl_t e;
    for (int i = 0; i < (w < WT ? w : WT); i++) begin
      e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      cyc(1'b0, "fetch_wait", e);
    end
    e = '0; e.alu_src_b = 2'b01;
    if (w >= WT) begin
      e.mem_timeout = 1'b1;
      cyc(1'b0, "fetch_timeout", e);
      ok = 1'b0;
    end else begin
      e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      cyc(1'b1, "fetch", e);
      ok = 1'b1;
    end
  endtask
  task automatic mem_acc(input bit wr, input int w, output bit ok);
    ctrl_t e;
    for (int i = 0; i < (w < WT ? w : WT); i++) begin
      e = '0; e.i_or_d = 1'b1; e.mem_read = !wr; e.mem_write = wr;
      cyc(1'b0, wr ? "memwr_wait" : "memrd_wait", e);
    end
    e = '0; e.i_or_d = 1'b1;
    if (w >= WT) begin
      e.mem_timeout = 1'b1;
      cyc(1'b0, "mem_timeout", e);
      ok = 1'b0;
    end else begin
      e.mem_read = !wr; e.mem_write = wr;
      cyc(1'b1, wr ? "memwr" : "memrd", e);
      ok = 1'b1;
    end
  endtask
  // One instruction from its first FETCH cycle up to (not including) the next FETCH.
  task automatic instr(input logic [5:0] o, input int wf, input int wm);
    ctrl_t e;
    bit ok;
    op = o;
    fetch(wf, ok);
    if (!ok) return;
    e = '0; e.alu_src_b = 2'b11;
    cyc(1'($urandom), "decode", e);
    case (o)
      RT: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        cyc(1'($urandom), "exec", e);
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b01;
        cyc(1'($urandom), "aluwb", e);
      end
      LW, SW: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc(1'($urandom), "memadr", e);
        mem_acc(o == SW, wm, ok);
        if (ok && o == LW) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
          cyc(1'($urandom), "memwb", e);
        end
      end
      BQ: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.branch = 1'b1; e.pc_src = 2'b01;
        cyc(1'($urandom), "beq", e);
      end
      AI, OI: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = o == OI ? 2'b11 : 2'b00;
        cyc(1'($urandom), o == OI ? "oriex" : "addiex", e);
        e = '0; e.reg_write = 1'b1;
        cyc(1'($urandom), "iwb", e);
      end
      JJ: begin
        e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10;
        cyc(1'($urandom), "jump", e);
      end
      JL: begin
        e = '0; e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        cyc(1'($urandom), "jal", e);
      end
      default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        e = '0; e.illegal_op = 1'b1;
        repeat (3) cyc(1'($urandom), "trap", e);
        do_reset();
`endif
      end
    endcase
  endtask
  initial begin
    logic [5:0] ops [8] = '{RT, LW, SW, BQ, AI, OI, JJ, JL};
    logic [5:0] o;
    ctrl_t e;
    #1 rst_n = 1'b0;
    #1 chk("reset_state", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, "idle", '0);
    op = RT;
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b1, "fetch", e);
    e = '0; e.alu_src_b = 2'b11;
    cyc(1'b1, "decode", e);
    mem_ready = 1'b1;
    @(negedge clk);
    e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
    chk("exec", e);
    #2 do_reset();
    instr(RT, 0, 0);
    instr(LW, 0, 3);
    instr(JL, 0, 0);
    instr(SW, 2, 1);
    instr(RT, WT, 0);
    instr(AI, WT - 1, 0);
    instr(LW, 0, WT);
    instr(SW, 1, WT);
    instr(LW, 0, WT - 1);
    instr(6'b111111, 0, 0);
    instr(BQ, 0, 0);
    instr(OI, 0, 0);
    instr(JJ, 0, 0);
    repeat (300) begin
      if ($urandom_range(0, 9) == 0)
        do o = 6'($urandom); while (o inside {RT, LW, SW, BQ, AI, OI, JJ, JL});
      else o = ops[$urandom_range(0, 7)];
      instr(o, $urandom_range(0, 5) == 0 ? $urandom_range(13, 16) : $urandom_range(0, 3),
            $urandom_range(0, 5) == 0 ? $urandom_range(13, 16) : $urandom_range(0, 3));
    end
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(1'b1, "final_fetch", e);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
